// File: rtl/simple_integral_if.sv
// Handshake and result bundle for the simple_integral antiderivative unit.
// master: drives start/base/root and reads results; slave: the unit itself.
interface simple_integral_if #(
    parameter int FRAC_BITS = 4
);
    localparam int QW = 4 + FRAC_BITS;

    logic          start;
    logic [3:0]    base;
    logic [3:0]    root;
    logic          busy;
    logic          done;
    logic [QW-1:0] coefout;
    logic [4:0]    remout;
    logic [4:0]    denomout;
    logic [7:0]    rootout;

    modport master (
        output start, base, root,
        input  busy, done, coefout, remout, denomout, rootout
    );

    modport slave (
        input  start, base, root,
        output busy, done, coefout, remout, denomout, rootout
    );
endinterface

// File: rtl/simple_integral.sv
// simple_integral: turns base*x^root into (base/(root+1))*x^(root+1).
// The coefficient is an unsigned fixed-point quotient with FRAC_BITS fraction
// bits, produced by a restoring divider, one quotient bit per cycle.
// Optional macro SIMPLE_INTEGRAL_ROUND_EN: round the quotient half up.
module simple_integral #(
    parameter int FRAC_BITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    simple_integral_if.slave  bus
);
    localparam int QW = 4 + FRAC_BITS;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t        state;
    logic [QW-1:0] dvd;
    logic [QW-1:0] quo;
    logic [5:0]    rem;
    logic [4:0]    dsr;
    logic [CW-1:0] cnt;
    logic [5:0]    rem_sh;
    logic [QW-1:0] coef_fin;

    // Partial remainder shifted left with the next dividend bit appended.
    always_comb begin
        rem_sh = {rem[4:0], dvd[QW-1]};
    end

    // Final coefficient: truncated or rounded half up from the last remainder.
    always_comb begin
`ifdef SIMPLE_INTEGRAL_ROUND_EN
        coef_fin = quo;
        if ({rem[4:0], 1'b0} >= {1'b0, dsr})
            coef_fin = quo + QW'(1);
`else
        coef_fin = quo;
`endif
    end

    // Control FSM, restoring divider datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dvd          <= '0;
            quo          <= '0;
            rem          <= '0;
            dsr          <= '0;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.coefout  <= '0;
            bus.remout   <= '0;
            bus.denomout <= '0;
            bus.rootout  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        if (bus.base != 4'd0) begin
                            dvd      <= {bus.base, {FRAC_BITS{1'b0}}};
                            dsr      <= {1'b0, bus.root} + 5'd1;
                            rem      <= '0;
                            quo      <= '0;
                            cnt      <= CW'(QW);
                            bus.busy <= 1'b1;
                            state    <= DIV;
                        end else begin
                            // Zero term: results and done are issued on the
                            // accepting edge; DONE only spends the cycle.
                            bus.coefout  <= '0;
                            bus.remout   <= '0;
                            bus.denomout <= '0;
                            bus.rootout  <= '0;
                            bus.done     <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DIV: begin
                    if (rem_sh >= {1'b0, dsr}) begin
                        rem <= rem_sh - {1'b0, dsr};
                        quo <= {quo[QW-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        quo <= {quo[QW-2:0], 1'b0};
                    end
                    dvd <= {dvd[QW-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bus.busy <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // done already high here means the zero-term shortcut
                    // produced its pulse; otherwise publish the division.
                    if (bus.done) begin
                        bus.done <= 1'b0;
                    end else begin
                        bus.coefout  <= coef_fin;
                        bus.remout   <= rem[4:0];
                        bus.denomout <= dsr;
                        bus.rootout  <= {3'b000, dsr};
                        bus.done     <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simple_integral.sv
// Bench for simple_integral: a cycle-indexed behavioural model checked on
// every falling edge, plus literal expectations from worked examples.
module tb_simple_integral;
    localparam int FRAC_BITS = 4;
    localparam int QW = 4 + FRAC_BITS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    simple_integral_if #(.FRAC_BITS(FRAC_BITS)) bus ();

    simple_integral #(.FRAC_BITS(FRAC_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: tracks edge numbers at which results are due.
    int e_n = 0, ready_e = 0, done_e = -1, busy_lo = 1, busy_hi = 0;
    int p_coef = 0, p_rem = 0, p_den = 0, p_root = 0;
    int m_coef = 0, m_rem = 0, m_den = 0, m_root = 0;
    int m_done = 0, m_busy = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ready_e = 0; done_e = -1; busy_lo = 1; busy_hi = 0;
                m_coef = 0; m_rem = 0; m_den = 0; m_root = 0;
                m_done = 0; m_busy = 0;
            end else begin
                e_n++;
                if (bus.start && e_n >= ready_e) begin
                    if (bus.base == 4'd0) begin
                        p_coef = 0; p_rem = 0; p_den = 0; p_root = 0;
                        done_e = e_n;
                        ready_e = e_n + 2;
                    end else begin
                        int n, d;
                        n = int'(bus.base) * (1 << FRAC_BITS);
                        d = int'(bus.root) + 1;
                        p_coef = n / d;
                        p_rem = n % d;
`ifdef SIMPLE_INTEGRAL_ROUND_EN
                        if (2 * p_rem >= d) p_coef++;
`endif
                        p_den = d;
                        p_root = d;
                        busy_lo = e_n;
                        busy_hi = e_n + QW - 1;
                        done_e = e_n + QW + 1;
                        ready_e = e_n + QW + 2;
                    end
                end
                m_busy = (e_n >= busy_lo && e_n <= busy_hi) ? 1 : 0;
                m_done = (e_n == done_e) ? 1 : 0;
                if (m_done != 0) begin
                    m_coef = p_coef; m_rem = p_rem; m_den = p_den; m_root = p_root;
                end
            end
        end
    end

    // Continuous comparison against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("coefout", 32'(bus.coefout), 32'(m_coef));
            chk("remout", 32'(bus.remout), 32'(m_rem));
            chk("denomout", 32'(bus.denomout), 32'(m_den));
            chk("rootout", 32'(bus.rootout), 32'(m_root));
        end
    end

    // One transaction with literal expectations and latency/busy counts.
    task automatic term(input logic [3:0] b, input logic [3:0] r, input int ec,
                        input int er, input int ed, input int eroot, input string nm);
        int lat, nbusy;
        bit got;
        repeat (2) @(negedge clk);
        bus.base = b; bus.root = r; bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        lat = 0; nbusy = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1;
            else begin
                lat++;
                if (bus.busy) nbusy++;
            end
        end
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        chk({nm, "_latency"}, 32'(lat), (b == 4'd0) ? 32'd0 : 32'(QW + 1));
        chk({nm, "_busy_cycles"}, 32'(nbusy), (b == 4'd0) ? 32'd0 : 32'(QW));
        chk({nm, "_coef"}, 32'(bus.coefout), 32'(ec));
        chk({nm, "_rem"}, 32'(bus.remout), 32'(er));
        chk({nm, "_denom"}, 32'(bus.denomout), 32'(ed));
        chk({nm, "_root"}, 32'(bus.rootout), 32'(eroot));
    endtask

    initial begin
        int ndone;
        bus.start = 1'b0; bus.base = '0; bus.root = '0;
        repeat (3) @(negedge clk);
        chk("rst_coef", 32'(bus.coefout), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        term(4'd6, 4'd2, 'h20, 0, 3, 3, "int_6_2");
        term(4'd5, 4'd1, 'h28, 0, 2, 2, "frac_5_1");
`ifdef SIMPLE_INTEGRAL_ROUND_EN
        term(4'd2, 4'd2, 'h0B, 2, 3, 3, "trunc_2_2");
`else
        term(4'd2, 4'd2, 'h0A, 2, 3, 3, "trunc_2_2");
`endif
        term(4'd15, 4'd15, 'h0F, 0, 16, 16, "max_15_15");
        term(4'd9, 4'd0, 'h90, 0, 1, 1, "root0_9_0");
        term(4'd0, 4'd7, 0, 0, 0, 0, "zero_0_7");

        // start held high; inputs change mid-division
        repeat (2) @(negedge clk);
        bus.base = 4'd1; bus.root = 4'd2; bus.start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) bus.base = 4'd15;
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    chk("hold_coef", 32'(bus.coefout), 32'h05);
                    chk("hold_rem", 32'(bus.remout), 32'd1);
                end
            end
        end
        chk("hold_done_count", 32'(ndone), 32'd3);
        bus.start = 1'b0;

        // reset during division
        repeat (12) @(negedge clk);
        bus.base = 4'd6; bus.root = 4'd2; bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_coef", 32'(bus.coefout), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        term(4'd6, 4'd2, 'h20, 0, 3, 3, "after_rst");

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #2;
            rst_n = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
            bus.start = ($urandom_range(3) == 0);
            bus.base = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom_range(15));
            bus.root = 4'($urandom_range(15));
        end
        @(posedge clk);
        #2 rst_n = 1'b1; bus.start = 1'b0;
        repeat (15) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/simple_integral.md
Name: simple_integral

Overview:
- Antiderivative counterpart of the calculator's derivative unit.
- Takes a monomial term base·x^root and produces (base/(root+1))·x^(root+1).
- The coefficient is computed as an unsigned fixed-point quotient by a multi-cycle restoring divider, under a start/busy/done handshake.
- Sits beside the derivative unit in the calculator datapath and feeds the same display/result path.

Parameters:
- FRAC_BITS, 4, number of fractional quotient bits. Internal QW = 4+FRAC_BITS (quotient width and iteration count).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- base  in  4  unsigned coefficient of the input term.
- root  in  4  unsigned exponent of the input term.
- busy  out  1  high while state is DIV.
- done  out  1  one-cycle pulse; results valid from this cycle.
- coefout  out  QW  quotient (base<<FRAC_BITS)/(root+1); unsigned, FRAC_BITS fractional bits.
- remout  out  5  final division remainder, always unrounded.
- denomout  out  5  divisor, root+1 (range 1..16).
- rootout  out  8  new exponent root+1, zero-extended.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0; done=0; coefout=0; remout=0; denomout=0; rootout=0; all internal registers cleared.
- Reset mid-operation aborts immediately with the same values; no done pulse is produced.
- States: IDLE, DIV, DONE.
- IDLE, start=1 and base!=0, at edge k:
  - latch dividend = base<<FRAC_BITS and divisor = root+1 (5-bit, no overflow);
  - clear the partial remainder; go to DIV; iteration counter = QW.
- IDLE, start=1 and base==0, at edge k:
  - go directly to DONE;
  - coefout=0, remout=0, denomout=0, rootout=0 (zero term, matching the derivative unit's zero handling).
- DIV: one quotient bit per cycle, MSB first (restoring).
  - rem' = {rem,next dividend bit}; if rem' >= divisor, subtract and set the quotient bit to 1.
  - The partial remainder is 6 bits wide, so no overflow is possible.
  - After QW DIV cycles, go to DONE (edge k+QW+1).
- DONE: done=1 for exactly one cycle; load the output registers; go to IDLE on the next edge.
- Latency: start accepted at edge k leads to done high in the cycle following edge k+QW+1 (QW+1 edges; 9 for FRAC_BITS=4). Zero shortcut: 1 edge.
- Outputs hold their last results until the next DONE or reset. They do not change during DIV.
- start while busy or in DONE is ignored; it is not queued.
- base and root are sampled only at acceptance. Changes during DIV have no effect.
- root=0 gives divisor 1, so coefout = base<<FRAC_BITS and rootout=1.
- root=15 gives divisor 16 and rootout=16.
- Maximum coefout is 15<<FRAC_BITS, which always fits in QW bits.

Optional Feature:
- Macro: SIMPLE_INTEGRAL_ROUND_EN.
- Defined: in DONE, coefout = quotient+1 when 2·remainder >= divisor (round half up), else quotient. No overflow is possible. remout still reports the unrounded remainder. Latency unchanged.
- Undefined: coefout is the truncated quotient.

Test Plan (FRAC_BITS=4):
- Integer result: base=6, root=2, start pulse → done after 9 edges; coefout=0x20 (2.0), remout=0, denomout=3, rootout=3; busy high for 8 cycles.
- Fractional and truncation: base=5, root=1 → coefout=0x28 (2.5), remout=0. Then base=2, root=2 → coefout=0x0A, remout=2, denomout=3. With SIMPLE_INTEGRAL_ROUND_EN the second case gives coefout=0x0B.
- Boundaries:
  - base=15, root=15 → coefout=0x0F, remout=0, denomout=16, rootout=16.
  - base=9, root=0 → coefout=0x90, rootout=1.
- Zero term: base=0, root=7 → done after 1 edge; all result outputs 0; busy never asserted.
- Handshake: start held high continuously with base=1, root=2 → exactly one done per 10 cycles (9 busy/DONE edges + 1 IDLE). Inputs changed to base=15 mid-DIV → result still coefout=0x05, remout=1.
- Reset: rst_n low at DIV cycle 4 → outputs 0 immediately, no done. After release, start base=6, root=2 → normal result 0x20.
